div_32bit_seq: RTL
==================

Name: div_32bit_seq

Overview:
Sequential 32-bit integer divider, the inverse-operation companion to the team's sequential 32-bit multiplier. It uses the same start/done handshake and the same signed_mode semantics. It computes quotient and remainder with a restoring algorithm, one quotient bit per cycle, and sits beside the multiplier in the integer execution path.

Parameters:
WIDTH, 32, operand/result width in bits (spec and tests written for 32)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state on the rising edge where high
start  input  1  request; sampled only when busy=0
signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; latched with start
op_a  input  WIDTH  dividend; latched with start
op_b  input  WIDTH  divisor; latched with start
busy  output  1  high from the edge accepting start until the edge asserting done
done  output  1  result valid; held high until the next accepted start or reset
div_by_zero  output  1  set with done when latched op_b==0; held with done
quotient_out  output  WIDTH  quotient, stable while done=1
remainder_out  output  WIDTH  remainder, stable while done=1

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, quotient_out=0, remainder_out=0; internal counters and registers cleared. Reset overrides start. Reset mid-operation aborts with no output update.
- States and transitions:
  - IDLE: start=1 latches operands and mode, busy<=1, done<=0, div_by_zero<=0, go to PREP.
  - PREP: if op_b==0, go to DONE with quotient=all-ones, remainder=op_a (raw), div_by_zero=1. Otherwise take magnitudes (signed_mode=1 and MSB set -> two's-complement negate), record q_neg = sign_a XOR sign_b and r_neg = sign_a (both 0 when unsigned), clear partial remainder and count, go to CALC.
  - CALC: each cycle, shift {rem, dividend} left 1 and trial-subtract divisor from the WIDTH+1-bit rem. If non-negative, keep the difference and set quotient bit 1; otherwise restore and set the bit 0. After WIDTH iterations (count 0..WIDTH-1) go to FIX.
  - FIX: negate quotient if q_neg and remainder if r_neg; register outputs; go to DONE.
  - DONE: done=1, busy=0. start=1 is accepted exactly as in IDLE, and done drops on that same edge.
- Latency: start accepted at edge k gives done=1 after edge k+WIDTH+2 (k+34 for 32). For divide-by-zero, done=1 after edge k+2.
- start while busy=1: ignored, no effect on the operation in progress.
- Arithmetic: truncation toward zero. Remainder takes the sign of the dividend. Invariant: op_a == quotient*op_b + remainder, modulo 2^WIDTH.
- Signed overflow (-2^31 / -1): quotient=0x80000000, remainder=0, div_by_zero=0. This falls out of the magnitude path naturally with no special case.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Shared package: WIDTH default constant; state enum (IDLE, PREP, CALC, FIX, DONE); counter width constant clog2(WIDTH)+1.
- One natural sub-module: div_restoring_step, a combinational single iteration. It takes the partial remainder, dividend shift register and divisor, and returns the next remainder, next shift register and quotient bit. The top module owns the FSM and registers.

Test Plan:
1. Unsigned 200/20 and 0xFFFFFFFF/0x10 -> q=10 r=0, then q=0x0FFFFFFF r=0xF. done rises exactly 34 cycles after the accepting edge; busy=1 throughout.
2. Signed 0xFFFFFF38(-200)/20 -> q=0xFFFFFFF6; -7/2 -> q=0xFFFFFFFD r=0xFFFFFFFF; 7/-2 -> q=0xFFFFFFFD r=1; -7/-2 -> q=3 r=0xFFFFFFFF.
3. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000 r=0, div_by_zero=0. Unsigned same operands -> q=0 r=0x80000000.
4. 5/0 in both modes -> q=0xFFFFFFFF r=5, div_by_zero=1, done 2 cycles after accept. The next start clears div_by_zero and done on the accepting edge.
5. Start held high and operands changed during CALC -> ignored; result matches the originally latched operands. Back-to-back start in DONE is accepted immediately.
6. Reset asserted at cycle 10 of CALC -> all outputs 0 after that edge, state IDLE; a new 100/7 then returns q=14 r=2.

Source files
------------

// File: rtl/div_32bit_seq_pkg.sv
// Shared definitions for the sequential 32-bit restoring divider.
//   DivWidth    : default operand/result width
//   DivCntWidth : width of the iteration counter for DivWidth
//   div_state_e : control FSM states
package div_32bit_seq_pkg;

  localparam int unsigned DivWidth    = 32;
  localparam int unsigned DivCntWidth = $clog2(DivWidth) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_32bit_seq_if.sv
// Request/response bundle for the sequential divider.
//   start, signed_mode, op_a, op_b : request, driven by the master
//   busy, done, div_by_zero        : status, driven by the divider
//   quotient_out, remainder_out    : results, stable while done=1
interface div_32bit_seq_if
  import div_32bit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) ();

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient_out;
  logic [WIDTH-1:0] remainder_out;

  modport master (
    output start, signed_mode, op_a, op_b,
    input  busy, done, div_by_zero, quotient_out, remainder_out
  );

  modport slave (
    input  start, signed_mode, op_a, op_b,
    output busy, done, div_by_zero, quotient_out, remainder_out
  );

endinterface

// File: rtl/div_32bit_seq_restoring_step.sv
// One combinational restoring-division iteration.
//   rem      : partial remainder (always < divisor)
//   dq       : dividend shift register; quotient bits fill in from the LSB
//   divisor  : divisor magnitude
//   next_rem : partial remainder after the trial subtraction/restore
//   next_dq  : shift register with the new quotient bit appended
//   q_bit    : quotient bit produced by this iteration
module div_restoring_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_dq,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem, dq[WIDTH-1]};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // rem < divisor keeps the true difference below 2^WIDTH, so the low bits suffice.
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign next_rem = q_bit ? diff : shifted[WIDTH-1:0];
  assign next_dq  = {dq[WIDTH-2:0], q_bit};

endmodule

// File: rtl/div_32bit_seq.sv
// Sequential restoring integer divider, one quotient bit per cycle.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : request (start/signed_mode/op_a/op_b) and registered results
//           (busy/done/div_by_zero/quotient_out/remainder_out)
// Results truncate toward zero; the remainder takes the dividend's sign.
module div_32bit_seq
  import div_32bit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic            clk,
  input  logic            reset,
  div_32bit_seq_if.slave  bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_e       state_q;
  logic             signed_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dbz_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] divisor_q;

  logic             busy_q;
  logic             done_q;
  logic             div_by_zero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dq;
  logic             step_qbit;

  // Magnitudes of the latched operands; -2^(W-1) maps to itself, which is
  // exactly the unsigned magnitude the core needs.
  always_comb begin
    sign_a = signed_q & dq_q[WIDTH-1];
    sign_b = signed_q & divisor_q[WIDTH-1];
    a_mag  = sign_a ? -dq_q : dq_q;
    b_mag  = sign_b ? -divisor_q : divisor_q;
  end

  div_restoring_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .dq       (dq_q),
    .divisor  (divisor_q),
    .next_rem (step_rem),
    .next_dq  (step_dq),
    .q_bit    (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      signed_q      <= 1'b0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dbz_q         <= 1'b0;
      count_q       <= '0;
      rem_q         <= '0;
      dq_q          <= '0;
      divisor_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            signed_q      <= bus.signed_mode;
            dq_q          <= bus.op_a;
            divisor_q     <= bus.op_b;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            state_q       <= StPrep;
          end
        end
        StPrep: begin
          if (divisor_q == '0) begin
            // Divide-by-zero skips CALC but still passes through FIX so the
            // raw dividend and all-ones quotient are published unmodified.
            rem_q   <= dq_q;
            dq_q    <= '1;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dbz_q   <= 1'b1;
            state_q <= StFix;
          end else begin
            dq_q      <= a_mag;
            divisor_q <= b_mag;
            rem_q     <= '0;
            count_q   <= '0;
            q_neg_q   <= sign_a ^ sign_b;
            r_neg_q   <= sign_a;
            dbz_q     <= 1'b0;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          rem_q   <= step_rem;
          dq_q    <= step_dq;
          count_q <= count_q + CntW'(1);
          if (count_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient_q    <= q_neg_q ? -dq_q : dq_q;
          remainder_q   <= r_neg_q ? -rem_q : rem_q;
          div_by_zero_q <= dbz_q;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.div_by_zero   = div_by_zero_q;
  assign bus.quotient_out  = quotient_q;
  assign bus.remainder_out = remainder_q;

endmodule
